// File: rtl/cafe_pkg.sv
// cafe_pkg: coin codes, denomination values, payment FSM encoding and prices shared with maquina_cafe.
// Revision 1.0
`default_nettype none

package cafe_pkg;

  localparam logic [2:0] MONEDA_25   = 3'b000;
  localparam logic [2:0] MONEDA_50   = 3'b001;
  localparam logic [2:0] MONEDA_100  = 3'b010;
  localparam logic [2:0] MONEDA_500  = 3'b011;
  localparam logic [2:0] MONEDA_1000 = 3'b100;
  localparam logic [2:0] MONEDA_2000 = 3'b101;

  localparam int VALOR_25   = 25;
  localparam int VALOR_50   = 50;
  localparam int VALOR_100  = 100;
  localparam int VALOR_500  = 500;
  localparam int VALOR_1000 = 1000;
  localparam int VALOR_2000 = 2000;

  typedef enum logic [1:0] {
    ESPERA     = 2'b00,
    COBRO      = 2'b01,
    PAGADO     = 2'b10,
    DEVOLUCION = 2'b11
  } estado_t;

  localparam int PRECIO_MAX            = 2500;
  localparam int VENTANA_PRECIO_CICLOS = 44;

  // Codes 110/111 map to zero; callers must qualify with the validity flag.
  function automatic int valor_moneda(input logic [2:0] codigo);
    case (codigo)
      MONEDA_25:   valor_moneda = VALOR_25;
      MONEDA_50:   valor_moneda = VALOR_50;
      MONEDA_100:  valor_moneda = VALOR_100;
      MONEDA_500:  valor_moneda = VALOR_500;
      MONEDA_1000: valor_moneda = VALOR_1000;
      MONEDA_2000: valor_moneda = VALOR_2000;
      default:     valor_moneda = 0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/modulo_pago_if.sv
// modulo_pago_if: price/coin/refund signals between maquina_cafe, the coin mechanism and modulo_pago.
// Revision 1.0
`default_nettype none

interface modulo_pago_if #(
  parameter int ANCHO = 16
);
  logic [ANCHO-1:0] precio_real;
  logic             moneda_valida;
  logic [2:0]       moneda;
  logic             cancelar;
  logic             PAGO_RECIBIDO;
  logic [ANCHO-1:0] credito;
  logic [ANCHO-1:0] vuelto;
  logic             vuelto_valido;
  logic             moneda_rechazada;
  logic             ocupado;

  modport master (
    output precio_real, moneda_valida, moneda, cancelar,
    input  PAGO_RECIBIDO, credito, vuelto, vuelto_valido, moneda_rechazada, ocupado
  );

  modport slave (
    input  precio_real, moneda_valida, moneda, cancelar,
    output PAGO_RECIBIDO, credito, vuelto, vuelto_valido, moneda_rechazada, ocupado
  );
endinterface

`default_nettype wire

// File: rtl/decodificador_moneda.sv
// decodificador_moneda: combinational map from 3-bit coin code to value and validity flag.
// Revision 1.0
`default_nettype none

module decodificador_moneda
  import cafe_pkg::*;
#(
  parameter int ANCHO = 16
) (
  input  logic [2:0]       codigo_i,
  output logic [ANCHO-1:0] valor_o,
  output logic             code_valido_o
);

  always_comb begin
    valor_o       = ANCHO'(valor_moneda(codigo_i));
    code_valido_o = (codigo_i <= MONEDA_2000);
  end

endmodule

`default_nettype wire

// File: rtl/modulo_pago.sv
// modulo_pago: arms on a new price, accumulates credit, signals payment and returns change or refund.
// Revision 1.0
`default_nettype none

module modulo_pago
  import cafe_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 40,
  parameter int ANCHO          = 16
) (
  input  logic          clock,
  input  logic          reset,
  modulo_pago_if.slave  bus
);

  localparam int          TW          = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_LIMITE = TW'(TIMEOUT_CICLOS - 1);

  estado_t          estado_q;
  logic [ANCHO-1:0] credito_q;
  logic [ANCHO-1:0] precio_reg_q;
  logic [TW-1:0]    timer_q;
  logic             precio_prev_nz_q;
  logic             pago_q;
  logic [ANCHO-1:0] vuelto_q;
  logic             vuelto_valido_q;
  logic             rechazada_q;
  logic             ocupado_q;

  logic [ANCHO-1:0] valor;
  logic             code_valido;
  logic             precio_nz;
  logic             armar;
  logic [ANCHO-1:0] credito_d;

  decodificador_moneda #(
    .ANCHO (ANCHO)
  ) u_decodificador (
    .codigo_i      (bus.moneda),
    .valor_o       (valor),
    .code_valido_o (code_valido)
  );

  // Arm only on the rising edge of "price pending" so a held price never re-arms.
  assign precio_nz = (bus.precio_real != '0);
  assign armar     = precio_nz && !precio_prev_nz_q;
  assign credito_d = credito_q + valor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q         <= ESPERA;
      credito_q        <= '0;
      precio_reg_q     <= '0;
      timer_q          <= '0;
      precio_prev_nz_q <= 1'b0;
      pago_q           <= 1'b0;
      vuelto_q         <= '0;
      vuelto_valido_q  <= 1'b0;
      rechazada_q      <= 1'b0;
      ocupado_q        <= 1'b0;
    end else begin
      precio_prev_nz_q <= precio_nz;
      pago_q           <= 1'b0;
      vuelto_q         <= '0;
      vuelto_valido_q  <= 1'b0;
      rechazada_q      <= 1'b0;

      case (estado_q)
        ESPERA: begin
          credito_q   <= '0;
          rechazada_q <= bus.moneda_valida;
          if (armar) begin
            precio_reg_q <= bus.precio_real;
            timer_q      <= '0;
            estado_q     <= COBRO;
            ocupado_q    <= 1'b1;
          end
        end

        COBRO: begin
          if (bus.cancelar || !precio_nz) begin
            rechazada_q <= bus.moneda_valida;
            estado_q    <= DEVOLUCION;
          end else if (bus.moneda_valida && code_valido) begin
            credito_q <= credito_d;
            timer_q   <= '0;
            if (credito_d >= precio_reg_q) begin
              estado_q <= PAGADO;
            end
          end else begin
            // Invalid codes are returned but do not restart the inactivity window.
            rechazada_q <= bus.moneda_valida;
            if (timer_q == TIMER_LIMITE) begin
              estado_q <= DEVOLUCION;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end

        PAGADO: begin
          pago_q          <= 1'b1;
          vuelto_q        <= credito_q - precio_reg_q;
          vuelto_valido_q <= 1'b1;
          rechazada_q     <= bus.moneda_valida;
          credito_q       <= '0;
          estado_q        <= ESPERA;
          ocupado_q       <= 1'b0;
        end

        DEVOLUCION: begin
          vuelto_q        <= credito_q;
          vuelto_valido_q <= 1'b1;
          rechazada_q     <= bus.moneda_valida;
          credito_q       <= '0;
          estado_q        <= ESPERA;
          ocupado_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PAGO_RECIBIDO    = pago_q;
  assign bus.credito          = credito_q;
  assign bus.vuelto           = vuelto_q;
  assign bus.vuelto_valido    = vuelto_valido_q;
  assign bus.moneda_rechazada = rechazada_q;
  assign bus.ocupado          = ocupado_q;

endmodule

`default_nettype wire

// File: tb/tb_modulo_pago.sv
// tb_modulo_pago: directed and randomized payment sessions checked against a credit/price model.
// Revision 1.0
`default_nettype none

module tb_modulo_pago;

  localparam int TIMEOUT = 40;
  localparam int W       = 16;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  int   m_credit;
  int   m_price;
  int   m_since;
  bit   paid;
  int   valores [8] = '{25, 50, 100, 500, 1000, 2000, 0, 0};

  modulo_pago_if #(.ANCHO(W)) bus ();

  modulo_pago #(
    .TIMEOUT_CICLOS (TIMEOUT),
    .ANCHO          (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic arm(input int price);
    bus.precio_real = '0;
    step();
    bus.precio_real = W'(price);
    step();
    m_price  = price;
    m_credit = 0;
    m_since  = 0;
    paid     = 0;
    chk("arm_ocupado", 32'(bus.ocupado), 1);
    chk("arm_credito", 32'(bus.credito), 0);
  endtask

  // Presents one coin while collecting; follows through to payment when credit covers the price.
  task automatic coin(input int code);
    bus.moneda_valida = 1'b1;
    bus.moneda        = 3'(code);
    step();
    bus.moneda_valida = 1'b0;
    if (code < 6) begin
      m_credit += valores[code];
      m_since   = 0;
      chk("coin_credito", 32'(bus.credito), 32'(m_credit));
      chk("coin_no_rechazo", 32'(bus.moneda_rechazada), 0);
      if (m_credit >= m_price) begin
        chk("pago_latencia", 32'(bus.PAGO_RECIBIDO), 0);
        step();
        chk("pago_pulso", 32'(bus.PAGO_RECIBIDO), 1);
        chk("pago_vv", 32'(bus.vuelto_valido), 1);
        chk("pago_vuelto", 32'(bus.vuelto), 32'(m_credit - m_price));
        chk("pago_ocupado", 32'(bus.ocupado), 0);
        step();
        chk("pago_un_ciclo", 32'(bus.PAGO_RECIBIDO), 0);
        chk("pago_credito0", 32'(bus.credito), 0);
        m_credit = 0;
        paid     = 1;
      end
    end else begin
      m_since++;
      chk("inval_rechazo", 32'(bus.moneda_rechazada), 1);
      chk("inval_credito", 32'(bus.credito), 32'(m_credit));
    end
  endtask

  // Steps until a refund pulse appears; returns the number of steps taken.
  task automatic wait_refund(output int n, output bit pago_visto);
    n          = 0;
    pago_visto = 0;
    while (!bus.vuelto_valido && n < 80) begin
      step();
      n++;
      if (bus.PAGO_RECIBIDO) pago_visto = 1;
    end
  endtask

  initial begin
    int  n;
    bit  pv;
    int  gap;
    int  code;
    int  guard;

    checks            = 0;
    errors            = 0;
    reset             = 1'b0;
    bus.precio_real   = '0;
    bus.moneda_valida = 1'b0;
    bus.moneda        = '0;
    bus.cancelar      = 1'b0;
    #2;
    chk("rst_pago", 32'(bus.PAGO_RECIBIDO), 0);
    chk("rst_credito", 32'(bus.credito), 0);
    chk("rst_vv", 32'(bus.vuelto_valido), 0);
    chk("rst_ocupado", 32'(bus.ocupado), 0);
    step();
    step();
    reset = 1'b1;
    step();

    // Exact payment.
    arm(500);
    coin(3);
    chk("exacto_pagado", 32'(paid), 1);

    // Overpayment, then the held price must not re-arm.
    arm(1250);
    coin(4);
    coin(2);
    coin(3);
    chk("sobrepago_pagado", 32'(paid), 1);
    repeat (5) step();
    chk("no_rearmar", 32'(bus.ocupado), 0);

    // Timeout refund.
    arm(750);
    coin(1);
    wait_refund(n, pv);
    chk("timeout_ciclos", 32'(n), 32'(TIMEOUT + 1));
    chk("timeout_vuelto", 32'(bus.vuelto), 50);
    chk("timeout_sin_pago", 32'(pv), 0);
    step();
    chk("timeout_espera", 32'(bus.ocupado), 0);

    // Cancel with a coin in the same cycle.
    arm(1000);
    coin(3);
    bus.cancelar      = 1'b1;
    bus.moneda_valida = 1'b1;
    bus.moneda        = 3'b011;
    step();
    bus.cancelar      = 1'b0;
    bus.moneda_valida = 1'b0;
    chk("cancel_rechazo", 32'(bus.moneda_rechazada), 1);
    chk("cancel_credito", 32'(bus.credito), 500);
    step();
    chk("cancel_vv", 32'(bus.vuelto_valido), 1);
    chk("cancel_vuelto", 32'(bus.vuelto), 500);
    chk("cancel_sin_pago", 32'(bus.PAGO_RECIBIDO), 0);

    // Invalid code keeps the inactivity timer running.
    arm(1000);
    coin(0);
    repeat (20) step();
    coin(6);
    wait_refund(n, pv);
    chk("inval_timer", 32'(n), 32'(TIMEOUT + 1 - 21));
    chk("inval_vuelto", 32'(bus.vuelto), 25);
    step();
    bus.moneda_valida = 1'b1;
    bus.moneda        = 3'b000;
    step();
    bus.moneda_valida = 1'b0;
    chk("espera_rechazo", 32'(bus.moneda_rechazada), 1);
    chk("espera_credito", 32'(bus.credito), 0);

    // Price withdrawn mid-collection refunds the credit.
    arm(300);
    coin(1);
    bus.precio_real = '0;
    step();
    step();
    chk("retiro_vv", 32'(bus.vuelto_valido), 1);
    chk("retiro_vuelto", 32'(bus.vuelto), 50);

    // Asynchronous reset with 600 credited.
    arm(1000);
    coin(3);
    coin(2);
    chk("pre_reset_credito", 32'(bus.credito), 600);
    #2;
    reset           = 1'b0;
    bus.precio_real = '0;
    #1;
    chk("areset_credito", 32'(bus.credito), 0);
    chk("areset_ocupado", 32'(bus.ocupado), 0);
    chk("areset_vv", 32'(bus.vuelto_valido), 0);
    step();
    reset = 1'b1;
    step();
    chk("post_reset_vv", 32'(bus.vuelto_valido), 0);
    arm(1500);
    coin(4);
    coin(3);
    chk("post_reset_pagado", 32'(paid), 1);

    // Randomized sessions with idle gaps and invalid codes.
    for (int t = 0; t < 10; t++) begin
      arm(int'($urandom_range(1, 100)) * 25);
      guard = 0;
      while (!paid && guard < 300) begin
        gap = int'($urandom_range(0, 4));
        repeat (gap) step();
        m_since += gap;
        code = (m_since > 20) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 7));
        coin(code);
        guard++;
      end
      chk("rnd_pagado", 32'(paid), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
